// File: rtl/vga_vram_arbiter.sv
// vga_vram_arbiter: shares one single-port VRAM between the deadline-driven display fetcher and a best-effort CPU port.
module vga_vram_arbiter #(
  parameter int ADDR_W   = 17,
  parameter int DATA_W   = 32,
  parameter int RAM_LAT  = 2,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk50MHz,
  input  logic              rst,
  input  logic              disp_req,
  input  logic              disp_urgent,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic {C_IDLE, C_BUSY} cpu_state_t;
  cpu_state_t cpu_state_q, cpu_state_d;
  logic [7:0] starve_cnt_q, starve_cnt_d;
  logic [RAM_LAT:0] tv_q, tc_q, tw_q;
  logic cpu_ok, starved, ret_disp, ret_cpu;
  assign cpu_ok   = cpu_req && cpu_state_q == C_IDLE;
  assign starved  = cpu_ok && starve_cnt_q == 8'(MAX_WAIT);
  // Urgent display beats a starved CPU; a starved CPU beats a relaxed display.
  assign disp_gnt = disp_req && (disp_urgent || !starved);
  assign cpu_gnt  = cpu_ok && !disp_gnt;
  assign ret_disp = tv_q[RAM_LAT] && !tc_q[RAM_LAT];
  assign ret_cpu  = tv_q[RAM_LAT] && tc_q[RAM_LAT];
  assign cpu_state_d  = cpu_gnt ? C_BUSY : cpu_ack ? C_IDLE : cpu_state_q;
  assign starve_cnt_d = (!cpu_req || cpu_gnt) ? 8'd0 :
                        (cpu_ok && starve_cnt_q != 8'(MAX_WAIT)) ? starve_cnt_q + 8'd1 : starve_cnt_q;
  always_ff @(posedge clk50MHz or posedge rst) begin
    if (rst) begin
      cpu_state_q  <= C_IDLE;
      starve_cnt_q <= '0;
      tv_q         <= '0;
      tc_q         <= '0;
      tw_q         <= '0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      disp_valid   <= 1'b0;
      disp_rdata   <= '0;
      cpu_ack      <= 1'b0;
      cpu_rdata    <= '0;
    end else begin
      cpu_state_q  <= cpu_state_d;
      starve_cnt_q <= starve_cnt_d;
      tv_q         <= {tv_q[RAM_LAT-1:0], disp_gnt || cpu_gnt};
      tc_q         <= {tc_q[RAM_LAT-1:0], cpu_gnt};
      tw_q         <= {tw_q[RAM_LAT-1:0], cpu_gnt && cpu_we};
      mem_en       <= disp_gnt || cpu_gnt;
      mem_we       <= cpu_gnt && cpu_we;
      mem_addr     <= disp_gnt ? disp_addr : cpu_gnt ? cpu_addr : '0;
      mem_wdata    <= (cpu_gnt && cpu_we) ? cpu_wdata : '0;
      disp_valid   <= ret_disp;
      cpu_ack      <= ret_cpu;
      if (ret_disp) disp_rdata <= mem_rdata;
      if (ret_cpu && !tw_q[RAM_LAT]) cpu_rdata <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_vga_vram_arbiter.sv
// tb_vga_vram_arbiter: directed and random traffic against a cycle-level reference of the arbitration rules.
module tb_vga_vram_arbiter;
  localparam int LAT  = 2;
  localparam int MAXW = 15;
  logic clk50MHz = 1'b0, rst = 1'b0;
  logic dreq = 1'b0, durg = 1'b0, creq = 1'b0, cwe = 1'b0;
  logic [16:0] daddr = '0, caddr = '0;
  logic [31:0] cwdata = '0, mem_rdata;
  logic disp_gnt, disp_valid, cpu_gnt, cpu_ack, mem_en, mem_we;
  logic [31:0] disp_rdata, cpu_rdata, mem_wdata;
  logic [16:0] mem_addr;

  vga_vram_arbiter #(.ADDR_W(17), .DATA_W(32), .RAM_LAT(LAT), .MAX_WAIT(MAXW)) dut (
    .clk50MHz(clk50MHz), .rst(rst),
    .disp_req(dreq), .disp_urgent(durg), .disp_addr(daddr),
    .disp_gnt(disp_gnt), .disp_valid(disp_valid), .disp_rdata(disp_rdata),
    .cpu_req(creq), .cpu_we(cwe), .cpu_addr(caddr), .cpu_wdata(cwdata),
    .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #10 clk50MHz = ~clk50MHz;

  // Behavioural VRAM: unwritten words read back as their own address.
  logic [31:0] ram [logic [16:0]];
  logic [31:0] rq [$];
  always @(negedge clk50MHz) begin
    logic [31:0] v;
    v = '0;
    if (mem_en === 1'b1 && mem_we === 1'b1) ram[mem_addr] = mem_wdata;
    else if (mem_en === 1'b1) v = ram.exists(mem_addr) ? ram[mem_addr] : 32'(mem_addr);
    rq.push_back(v);
    if (rq.size() > LAT) mem_rdata = rq.pop_front();
  end

  typedef struct {bit en; bit we; logic [16:0] a; logic [31:0] d;} iss_t;
  iss_t exp_iss [int];
  logic [31:0] exp_d [int];
  logic [31:0] exp_c [int];
  logic [31:0] mdl [logic [16:0]];
  logic [31:0] last_rd = '0;
  int cyc = 0, cpu_free = 0, w = 0, obs_cg_cyc = -1;
  bit gd = 0, gc = 0;
  int ntests = 0, nfail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] mdl_rd(input logic [16:0] a);
    return mdl.exists(a) ? mdl[a] : 32'(a);
  endfunction

  // Evaluate one cycle: expected grant from the priority list, then registered outputs after the edge.
  task automatic tick();
    int win;
    bit c_ok;
    iss_t e;
    #1;
    win = 0;
    c_ok = creq && cyc >= cpu_free;
    if (dreq && durg) win = 1;
    else if (c_ok && w == MAXW) win = 2;
    else if (dreq) win = 1;
    else if (c_ok) win = 2;
    chk("disp_gnt", disp_gnt, win == 1);
    chk("cpu_gnt", cpu_gnt, win == 2);
    if (cpu_gnt === 1'b1) obs_cg_cyc = cyc;
    gd = win == 1;
    gc = win == 2;
    if (gd) begin
      exp_iss[cyc+1] = '{1'b1, 1'b0, daddr, 32'h0};
      exp_d[cyc+LAT+2] = mdl_rd(daddr);
    end
    if (gc) begin
      exp_iss[cyc+1] = '{1'b1, cwe, caddr, cwdata};
      if (cwe) mdl[caddr] = cwdata;
      else last_rd = mdl_rd(caddr);
      exp_c[cyc+LAT+2] = last_rd;
      cpu_free = cyc + LAT + 3;
    end
    if (!creq || gc) w = 0;
    else if (c_ok && w < MAXW) w++;
    @(posedge clk50MHz); #1;
    cyc++;
    e = exp_iss.exists(cyc) ? exp_iss[cyc] : '{1'b0, 1'b0, 17'h0, 32'h0};
    chk("mem_en", mem_en, e.en);
    if (e.en) begin
      chk("mem_we", mem_we, e.we);
      chk("mem_addr", mem_addr, e.a);
      if (e.we) chk("mem_wdata", mem_wdata, e.d);
    end
    chk("disp_valid", disp_valid, exp_d.exists(cyc));
    if (exp_d.exists(cyc)) chk("disp_rdata", disp_rdata, exp_d[cyc]);
    chk("cpu_ack", cpu_ack, exp_c.exists(cyc));
    if (exp_c.exists(cyc)) chk("cpu_rdata", cpu_rdata, exp_c[cyc]);
  endtask

  task automatic pulse_reset();
    dreq = 0; creq = 0; durg = 0;
    #2 rst = 1'b1;
    #1;
    chk("rst_disp_gnt", disp_gnt, 0);
    chk("rst_disp_valid", disp_valid, 0);
    chk("rst_disp_rdata", disp_rdata, 0);
    chk("rst_cpu_gnt", cpu_gnt, 0);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    exp_iss.delete(); exp_d.delete(); exp_c.delete();
    w = 0; cpu_free = 0; last_rd = '0; gd = 0; gc = 0;
    @(posedge clk50MHz); #1;
    cyc++;
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    dreq = 0; creq = 0; durg = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cpu_op(input bit we, input logic [16:0] a, input logic [31:0] d);
    int i;
    creq = 1; cwe = we; caddr = a; cwdata = d;
    for (i = 0; i < 40 && !gc; i++) tick();
    if (!gc) chk("cpu_op_timeout", 1, 0);
    creq = 0; gc = 0;
    idle(LAT + 3);
  endtask

  initial begin
    @(posedge clk50MHz); #1;
    pulse_reset();
    // Display stream of 8 back-to-back reads
    for (int i = 0; i < 8; i++) begin dreq = 1; daddr = 17'(i); tick(); end
    idle(LAT + 3);
    // CPU write then read-back
    cpu_op(1'b1, 17'h100, 32'hDEADBEEF);
    cpu_op(1'b0, 17'h100, 32'h0);
    // Starvation: relaxed display held, CPU must win after MAX_WAIT cycles
    begin
      int k0, i;
      obs_cg_cyc = -1;
      dreq = 1; daddr = 17'h40; creq = 1; cwe = 0; caddr = 17'h100;
      k0 = cyc;
      for (i = 0; i < 40 && obs_cg_cyc < 0; i++) begin
        tick();
        if (gd) daddr = daddr + 17'd1;
      end
      chk("starve_gap", obs_cg_cyc - k0, MAXW);
      creq = 0;
      idle(LAT + 3);
    end
    // Urgent display holds off a saturated CPU until urgency drops
    begin
      int k0;
      dreq = 1; durg = 1; daddr = 17'h80; creq = 1; cwe = 0; caddr = 17'h100;
      obs_cg_cyc = -1;
      for (int i = 0; i < 20; i++) begin tick(); daddr = daddr + 17'd1; end
      chk("urgent_blocks_cpu", obs_cg_cyc, 32'hFFFFFFFF);
      durg = 0; k0 = cyc;
      tick();
      chk("cpu_after_urgent", obs_cg_cyc - k0, 0);
      idle(LAT + 3);
    end
    // Simultaneous requests, no deadline pressure
    dreq = 1; daddr = 17'h20; creq = 1; cwe = 0; caddr = 17'h100;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (gd) daddr = daddr + 17'd1;
      if (gc) creq = 0;
      if (i == 2) dreq = 0;
    end
    idle(LAT + 4);
    // Reset with three reads in flight
    dreq = 1; daddr = 17'h7; creq = 1; cwe = 0; caddr = 17'h100;
    tick(); daddr = 17'h8;
    tick(); dreq = 0;
    tick();
    pulse_reset();
    idle(LAT + 4);
    // Random mixed traffic
    for (int i = 0; i < 3000; i++) begin
      if (gd || !dreq) begin dreq = $urandom_range(7) != 0; daddr = 17'($urandom_range(63)); end
      else if ($urandom_range(15) == 0) dreq = 0;
      durg = $urandom_range(7) == 0;
      if (gc || !creq) begin
        creq = $urandom_range(1) != 0; cwe = $urandom_range(1) != 0;
        caddr = 17'($urandom_range(63)); cwdata = $urandom;
      end else if ($urandom_range(31) == 0) creq = 0;
      tick();
    end
    idle(LAT + 4);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
